// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// Imported by the RX feeder and reused by the future TX block.
package uart_pkg;

    localparam int DIV_W      = 16;
    localparam int OVS        = 16;
    localparam int MID_SAMPLE = 7;
    localparam int D_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_rx_fifo_feeder_if.sv
// Write-side port of the async RX FIFO as seen from the UART receiver.
// wrreq is a one-cycle strobe qualifying data; wrfull is the FIFO's registered
// full flag, and the producer must not strobe while it is high.
interface uart_rx_fifo_feeder_if #(
    parameter int D_W = 8
) ();
    logic           wrreq;
    logic [D_W-1:0] data;
    logic           wrfull;

    modport master (output wrreq, output data, input  wrfull);
    modport slave  (input  wrreq, input  data, output wrfull);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divisor counter with a period of
// i_div+1 cycles, held at zero while disabled and restartable via i_reload.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_soft_rst_n,
    input  logic             i_en,
    input  logic             i_reload,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_soft_rst_n || !i_en || i_reload) begin
            r_cnt <= '0;
        end else if (r_cnt == i_div) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == i_div);

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// 16x-oversampling UART receiver (8N1 / 8E1 / 8O1) that pushes good bytes into
// the RX FIFO write port and keeps sticky framing/parity/overrun flags.
module uart_rx_fifo_feeder #(
    parameter int DIV_W = 16,
    parameter int OVS   = 16,
    parameter int D_W   = 8
) (
    input  logic                  wrclk,
    input  logic                  wr_rst,
    input  logic                  wr_soft_rst,
    input  logic                  rx_en,
    input  logic                  rxd,
    input  logic [DIV_W-1:0]      baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  clr_err,
    uart_rx_fifo_feeder_if.master fifo,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    output uart_pkg::uart_state_t dbg_state
);

    import uart_pkg::*;

    localparam int                ST_W     = $clog2(OVS);
    localparam int                IDX_W    = $clog2(D_W);
    localparam logic [ST_W-1:0]   ST_MID   = ST_W'(MID_SAMPLE);
    localparam logic [ST_W-1:0]   ST_LAST  = ST_W'(OVS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(D_W - 1);

    logic             r_rx_meta;
    logic             r_rxs;
    uart_state_t      r_state;
    logic [ST_W-1:0]  r_st;
    logic [IDX_W-1:0] r_idx;
    logic [D_W-1:0]   r_shift;
    logic             r_perr;
    logic             r_wrreq;
    logic [D_W-1:0]   r_data;
    logic             r_frame_err;
    logic             r_parity_err;
    logic             r_overrun;

    uart_state_t      w_state_nxt;
    logic [ST_W-1:0]  w_st_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [D_W-1:0]   w_shift_nxt;
    logic             w_perr_nxt;
    logic             w_wrreq_nxt;
    logic [D_W-1:0]   w_data_nxt;
    logic             w_frame_err_nxt;
    logic             w_parity_err_nxt;
    logic             w_overrun_nxt;
    logic             w_tick;
    logic             w_reload;
    logic             w_mid;
    logic             w_end;

    always_ff @(posedge wrclk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else if (!wr_soft_rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rxs     <= r_rx_meta;
        end
    end

    // Restarting the divisor on the start edge centres every sample on its bit.
    assign w_reload = rx_en && (r_state == ST_IDLE) && !r_rxs;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .i_clk        (wrclk),
        .i_rst_n      (wr_rst),
        .i_soft_rst_n (wr_soft_rst),
        .i_en         (rx_en),
        .i_reload     (w_reload),
        .i_div        (baud_div),
        .o_tick       (w_tick)
    );

    assign w_mid = w_tick && (r_st == ST_MID);
    assign w_end = w_tick && (r_st == ST_LAST);

    always_ff @(posedge wrclk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_state      <= ST_IDLE;
            r_st         <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_wrreq      <= 1'b0;
            r_data       <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_st         <= w_st_nxt;
            r_idx        <= w_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_perr       <= w_perr_nxt;
            r_wrreq      <= w_wrreq_nxt;
            r_data       <= w_data_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_st_nxt         = r_st;
        w_idx_nxt        = r_idx;
        w_shift_nxt      = r_shift;
        w_perr_nxt       = r_perr;
        w_wrreq_nxt      = 1'b0;
        w_data_nxt       = r_data;
        w_frame_err_nxt  = r_frame_err  & ~clr_err;
        w_parity_err_nxt = r_parity_err & ~clr_err;
        w_overrun_nxt    = r_overrun    & ~clr_err;

        if (w_tick) begin
            w_st_nxt = r_st + 1'b1;
        end

        unique case (r_state)
            ST_IDLE: begin
                w_st_nxt = '0;
                if (w_reload) begin
                    w_state_nxt = ST_START;
                    w_idx_nxt   = '0;
                    w_perr_nxt  = 1'b0;
                end
            end
            ST_START: begin
                if (w_mid && r_rxs) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_end) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_mid) begin
                    w_shift_nxt = {r_rxs, r_shift[D_W-1:1]};
                end
                if (w_end) begin
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = parity_en ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_mid && (r_rxs != (^r_shift ^ parity_odd))) begin
                    w_perr_nxt = 1'b1;
                end
                if (w_end) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Decide at mid-stop so a start bit right after the stop bit is caught.
                if (w_mid) begin
                    if (!r_rxs) begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = ST_BREAK;
                    end else if (r_perr) begin
                        w_parity_err_nxt = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end else if (fifo.wrfull) begin
                        w_overrun_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_wrreq_nxt = 1'b1;
                        w_data_nxt  = r_shift;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (r_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (!rx_en) begin
            w_state_nxt = ST_IDLE;
            w_st_nxt    = '0;
            w_wrreq_nxt = 1'b0;
        end

        if (!wr_soft_rst) begin
            w_state_nxt      = ST_IDLE;
            w_st_nxt         = '0;
            w_idx_nxt        = '0;
            w_shift_nxt      = '0;
            w_perr_nxt       = 1'b0;
            w_wrreq_nxt      = 1'b0;
            w_data_nxt       = '0;
            w_frame_err_nxt  = 1'b0;
            w_parity_err_nxt = 1'b0;
            w_overrun_nxt    = 1'b0;
        end
    end

    assign fifo.wrreq = r_wrreq;
    assign fifo.data  = r_data;
    assign busy       = (r_state != ST_IDLE);
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Bench for uart_rx_fifo_feeder: directed frames from the test plan followed by
// randomized frames, scored against a frame-level reference model.
module tb_uart_rx_fifo_feeder;

    import uart_pkg::*;

    localparam int TB_OVS = 16;

    logic        wrclk       = 1'b0;
    logic        wr_rst      = 1'b1;
    logic        wr_soft_rst = 1'b1;
    logic        rx_en       = 1'b0;
    logic        rxd         = 1'b1;
    logic [15:0] baud_div    = 16'd3;
    logic        parity_en   = 1'b0;
    logic        parity_odd  = 1'b0;
    logic        clr_err     = 1'b0;
    logic        busy;
    logic        frame_err;
    logic        parity_err;
    logic        overrun;
    uart_state_t dbg_state;

    uart_rx_fifo_feeder_if #(.D_W(8)) ifc ();

    uart_rx_fifo_feeder dut (
        .wrclk       (wrclk),
        .wr_rst      (wr_rst),
        .wr_soft_rst (wr_soft_rst),
        .rx_en       (rx_en),
        .rxd         (rxd),
        .baud_div    (baud_div),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .clr_err     (clr_err),
        .fifo        (ifc.master),
        .busy        (busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    always #5 wrclk = ~wrclk;

    int         n_checks    = 0;
    int         n_pass      = 0;
    int         cyc         = 0;
    int         wr_count    = 0;
    int         last_wr_cyc = 0;
    int         t_start     = 0;
    logic       prev_wrreq  = 1'b0;
    logic [7:0] exp_q[$];
    logic       m_ferr      = 1'b0;
    logic       m_perr      = 1'b0;
    logic       m_ovr       = 1'b0;
    logic [7:0] m_data      = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge wrclk) cyc <= cyc + 1;

    // Scoreboard: every write strobe must match the oldest expected byte.
    always @(negedge wrclk) begin
        if (ifc.wrreq === 1'b1) begin
            check("wrreq_single_cycle", 32'(prev_wrreq), 0);
            check("wrreq_was_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("wr_data", 32'(ifc.data), 32'(exp_q.pop_front()));
            end
            wr_count++;
            last_wr_cyc = cyc;
        end
        prev_wrreq = ifc.wrreq;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge wrclk);
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        wait_cyc(TB_OVS * (int'(baud_div) + 1));
    endtask

    // Frame-level outcome: stop error beats parity error beats full FIFO.
    task automatic model_frame(input logic [7:0] b, input bit flip_par, input logic stop_b);
        if (!stop_b)                     m_ferr = 1'b1;
        else if (parity_en && flip_par)  m_perr = 1'b1;
        else if (ifc.wrfull)             m_ovr  = 1'b1;
        else begin
            exp_q.push_back(b);
            m_data = b;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop_b);
        model_frame(b, flip_par, stop_b);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (parity_en) drive_bit(^b ^ parity_odd ^ flip_par);
        drive_bit(stop_b);
    endtask

    task automatic model_clear();
        m_ferr = 1'b0;
        m_perr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err"},  32'(frame_err),  32'(m_ferr));
        check({tag, "_parity_err"}, 32'(parity_err), 32'(m_perr));
        check({tag, "_overrun"},    32'(overrun),    32'(m_ovr));
        check({tag, "_pending"},    32'(exp_q.size()), 0);
        check({tag, "_data_hold"},  32'(ifc.data),   32'(m_data));
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        wait_cyc(1);
        clr_err = 1'b0;
        model_clear();
        wait_cyc(2);
    endtask

    initial begin
        #900_000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int nom;
        int cnt0;
        logic [7:0] rb;
        bit         rflip;
        logic       rstop;
        ifc.wrfull = 1'b0;

        // Reset state
        #2 wr_rst = 1'b0;
        wait_cyc(3);
        check("rst_wrreq", 32'(ifc.wrreq), 0);
        check("rst_data",  32'(ifc.data),  0);
        check("rst_busy",  32'(busy),      0);
        check("rst_flags", 32'({frame_err, parity_err, overrun}), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        wr_rst = 1'b1;
        rx_en  = 1'b1;
        wait_cyc(5);

        // 8N1 0xA5 at baud_div=3 with latency window
        send_frame(8'hA5, 1'b0, 1'b1);
        rxd = 1'b1;
        wait_cyc(20);
        lat = last_wr_cyc - t_start;
        nom = 2 + ((9 * 16) + 8) * 4;
        check("a5_latency", 32'((lat >= nom - 4 && lat <= nom + 4) ? nom : lat), 32'(nom));
        check("a5_count", 32'(wr_count), 1);
        check_flags("a5");

        // Back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        rxd = 1'b1;
        wait_cyc(20);
        check("b2b_count", 32'(wr_count), 3);
        check_flags("b2b");

        // Even parity: good then bad, then clear
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b0, 1'b1);
        rxd = 1'b1;
        wait_cyc(20);
        check_flags("par_good");
        send_frame(8'h07, 1'b1, 1'b1);
        rxd = 1'b1;
        wait_cyc(20);
        check_flags("par_bad");
        pulse_clr();
        check_flags("par_clr");

        // Stop bit low followed by a held-low line
        parity_en = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cyc(500);
        check("brk_busy",  32'(busy), 1);
        check("brk_state", 32'(dbg_state), 32'(ST_BREAK));
        check_flags("brk");
        rxd = 1'b1;
        wait_cyc(5);
        check("brk_release_busy", 32'(busy), 0);

        // FIFO full drops byte, later byte still accepted
        ifc.wrfull = 1'b1;
        send_frame(8'h55, 1'b0, 1'b1);
        rxd = 1'b1;
        wait_cyc(20);
        ifc.wrfull = 1'b0;
        check_flags("ovr_drop");
        send_frame(8'h56, 1'b0, 1'b1);
        rxd = 1'b1;
        wait_cyc(20);
        check_flags("ovr_next");

        // rx_en dropped mid-frame
        cnt0 = wr_count;
        rxd = 1'b0;
        wait_cyc(100);
        rx_en = 1'b0;
        wait_cyc(1);
        check("abort_busy", 32'(busy), 0);
        rxd = 1'b1;
        rx_en = 1'b1;
        wait_cyc(20);
        check("abort_count", 32'(wr_count), 32'(cnt0));
        check_flags("abort");

        // Two-cycle glitch is a false start
        rxd = 1'b0;
        wait_cyc(2);
        rxd = 1'b1;
        wait_cyc(4);
        check("glitch_started", 32'(busy), 1);
        wait_cyc(60);
        check("glitch_idle", 32'(busy), 0);
        check("glitch_count", 32'(wr_count), 32'(cnt0));

        // Async reset mid-frame
        rxd = 1'b0;
        wait_cyc(200);
        #2 wr_rst = 1'b0;
        #1;
        check("arst_wrreq", 32'(ifc.wrreq), 0);
        check("arst_data",  32'(ifc.data),  0);
        check("arst_busy",  32'(busy),      0);
        check("arst_flags", 32'({frame_err, parity_err, overrun}), 0);
        @(negedge wrclk);
        rxd    = 1'b1;
        wr_rst = 1'b1;
        model_clear();
        m_data = 8'h00;
        wait_cyc(5);
        send_frame(8'h81, 1'b0, 1'b1);
        rxd = 1'b1;
        wait_cyc(20);
        check_flags("post_rst");

        // Soft reset clears flags and data
        ifc.wrfull = 1'b1;
        send_frame(8'h12, 1'b0, 1'b1);
        rxd = 1'b1;
        wait_cyc(20);
        ifc.wrfull = 1'b0;
        check_flags("pre_soft");
        wr_soft_rst = 1'b0;
        wait_cyc(1);
        wr_soft_rst = 1'b1;
        model_clear();
        m_data = 8'h00;
        wait_cyc(2);
        check_flags("soft_rst");

        // Randomized frames
        for (int n = 0; n < 14; n++) begin
            baud_div   = 16'($urandom_range(0, 3));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            rb         = 8'($urandom_range(0, 255));
            rflip      = ($urandom_range(0, 3) == 0);
            rstop      = ($urandom_range(0, 5) != 0);
            ifc.wrfull = ($urandom_range(0, 4) == 0);
            send_frame(rb, rflip, rstop);
            rxd = 1'b1;
            wait_cyc(TB_OVS * (int'(baud_div) + 1));
            ifc.wrfull = 1'b0;
            check_flags("rnd");
            if ($urandom_range(0, 2) == 0) begin
                pulse_clr();
                check_flags("rnd_clr");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_feeder.md
Name: uart_rx_fifo_feeder

Overview:
UART receiver for the RISC-V core peripheral set. It oversamples the serial line 16x, deserialises 8N1 or 8E1/8O1 frames, and pushes each good byte into the write port of the 256-entry async RX FIFO. It lives entirely in the wrclk domain. It reports framing, parity and overrun errors as sticky flags for the register block.

Parameters:
DIV_W, 16, width of the baud divisor
OVS, 16, oversampling ratio (fixed; ticks per bit)
D_W, 8, data bits per frame and FIFO data width

Ports:
wrclk  input  1  peripheral/FIFO write clock
wr_rst  input  1  reset, asynchronous, active-low
wr_soft_rst  input  1  synchronous soft reset, active-low
rx_en  input  1  receiver enable
rxd  input  1  asynchronous serial input, idle high
baud_div  input  DIV_W  oversample tick period minus 1
parity_en  input  1  parity bit present
parity_odd  input  1  1 = odd parity, 0 = even parity
clr_err  input  1  one-cycle pulse that clears all sticky flags
wrfull  input  1  FIFO write-side full flag
wrreq  output  1  FIFO write strobe, one-cycle pulse
data  output  D_W  FIFO write data
busy  output  1  frame reception in progress
frame_err  output  1  sticky: stop bit sampled low
parity_err  output  1  sticky: parity mismatch
overrun  output  1  sticky: good byte dropped because FIFO full

Behaviour:
- Reset:
  - wr_rst low (async) or wr_soft_rst low (sync) clears all state.
  - Outputs after reset: wrreq=0, data=0, busy=0, all flags=0.
  - Synchroniser flops reset to 1.
- Input sync: rxd passes through 2 flops; all logic uses the synchronised value rxs.
- Tick generator:
  - Counter cnt runs 0..baud_div and asserts tick when cnt==baud_div, giving a period of baud_div+1 cycles.
  - baud_div=0 gives a tick every cycle.
  - The counter runs only while rx_en=1 and is reloaded to 0 on entry to START.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: when rx_en and rxs==0, go to START with sub-tick counter st=0.
  - All states: st counts ticks 0..15. The bit is sampled at st==7, the mid-bit point. A bit ends at st==15.
  - START: at mid-bit, rxs==1 is a false start and returns to IDLE; otherwise continue to DATA at the end of the bit.
  - DATA:
    - 8 bits, LSB first, shifted into shift[7:0].
    - bit index 0..7 wraps via a 3-bit counter.
    - After bit 7 ends, go to PARITY if parity_en, else STOP.
  - PARITY:
    - Compare the sampled bit with ^shift ^ parity_odd; a mismatch sets the local perr.
    - Go to STOP at the end of the bit.
  - STOP (acts at the mid-bit sample, not at the end of the bit):
    - rxs==0: set frame_err and drop the byte. Go to BREAK.
    - Else perr: set parity_err and drop the byte. Go to IDLE.
    - Else wrfull==1: set overrun and drop the byte. Go to IDLE.
    - Else: on the next cycle assert wrreq for exactly one cycle with data=shift. Go to IDLE.
    - Returning to IDLE at mid-stop permits back-to-back frames.
  - BREAK: wait for rxs==1, then go to IDLE. This covers line-break recovery.
- data holds its last written value between writes. wrreq is never asserted outside the STOP-success path.
- Latency: wrreq is asserted 1 cycle after the mid-stop tick. That is 2 (sync) + ((9+parity_en)*16+8)*(baud_div+1) cycles after the rxd falling edge, ±1 tick.
- Full flag: wrfull is the FIFO's registered flag. This block writes at most once per ≥160 cycles, so the one-cycle status lag is safe with no extra margin logic.
- busy = (state != IDLE).
- rx_en deasserted mid-frame: abort to IDLE at once with no write and no flags.
- Error flags:
  - Flags are sticky until clr_err.
  - If clr_err coincides with a new error set in the same cycle, the set wins.
- Parameter changes (baud_div, parity_en, parity_odd) while busy are undefined; software changes them only while idle.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding enum (3 bits) for IDLE/START/DATA/PARITY/STOP/BREAK;
  - constants OVS=16 and MID_SAMPLE=7;
  - DIV_W.
- One sub-module, uart_baud_tick: the divisor counter with tick and reload inputs. It is reused by the future TX block.

Test Plan:
- baud_div=3, 8N1, send 0xA5 → one wrreq pulse with data=0xA5 at ≈610 cycles after the falling edge; no flags set.
- Two back-to-back frames 0x00 then 0xFF with no idle gap → two wrreq pulses, data=0x00 then 0xFF.
- parity_en=1, parity_odd=0:
  - send 0x07 with parity bit 1 → written, no error;
  - repeat with parity bit 0 → no wrreq, parity_err=1;
  - clr_err pulse → parity_err=0.
- Stop bit driven 0 on 0x3C, then line held low 500 cycles, then released → no wrreq, frame_err=1, busy stays 1 until rxd returns high.
- wrfull=1 held while sending 0x55 → no wrreq, overrun=1. Drop wrfull, send 0x56 → wrreq with data=0x56, overrun still 1.
- 2-cycle low glitch on rxd → false start, back to IDLE, no wrreq. Then assert wr_rst mid-frame → all outputs 0 immediately; the next clean frame 0x81 is received correctly.
